// File: rtl/adc_capture_buffer.sv
// Multi-channel ADC capture buffer: decimates accepted samples, serialises them into
// channel-tagged 16-bit words and queues them in a synchronous FIFO for the host pipe.
module adc_capture_buffer #(
  parameter int PRECISION   = 10,
  parameter int CHANNELS    = 2,
  parameter int DEPTH_LOG2  = 10,
  parameter int DECIM_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sample_valid,
  input  logic [CHANNELS*PRECISION-1:0] sample_data,
  input  logic                          arm,
  input  logic                          stop,
  input  logic                          mode,
  input  logic [DEPTH_LOG2:0]           capture_len,
  input  logic [DECIM_WIDTH-1:0]        decim,
  input  logic                          clear_flags,
  input  logic                          rd_en,
  output logic [15:0]                   rd_data,
  output logic                          rd_valid,
  output logic [DEPTH_LOG2:0]           fill_count,
  output logic                          empty,
  output logic                          full,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow_sticky,
  output logic                          underflow_sticky,
  output logic [15:0]                   drop_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam int DW    = CHANNELS * PRECISION;
  localparam logic [CNT_W-1:0] SPACE_LIM = CNT_W'(DEPTH - CHANNELS);
  localparam logic [3:0]       LAST_CH   = 4'(CHANNELS - 1);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

  state_t                  state, state_nx;
  logic                    mode_q, stop_pend;
  logic [CNT_W-1:0]        len_q, samp_cnt;
  logic [DECIM_WIDTH-1:0]  decim_q, dec_cnt;
  logic                    vld_p0;
  logic [3:0]              ch_p0;
  logic [DW-1:0]           data_p0;
  logic [15:0]             mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        fill_nx;
  logic arm_ok, ss_complete, live, cand, accept, drop, wr_en, last_word, do_rd, rd_empty;

  function automatic logic [15:0] pack_word(input logic [3:0] ch, input logic [PRECISION-1:0] code);
    logic [15:0] w;
    w = '0;
    w[15:12] = ch;
    w[PRECISION-1:0] = code;
    return w;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign arm_ok      = arm && !stop && (state != S_CAPTURE);
  assign ss_complete = mode_q && (samp_cnt == len_q);
  // New candidates are only considered while the capture is not winding down.
  assign live        = (state == S_CAPTURE) && !stop && !stop_pend && !ss_complete;
  assign cand        = live && sample_valid && (dec_cnt == '0);
  assign accept      = cand && !vld_p0 && (fill_count <= SPACE_LIM);
  assign drop        = cand && !accept;
  assign wr_en       = vld_p0;
  assign last_word   = vld_p0 && (ch_p0 == LAST_CH);
  assign do_rd       = rd_en && !empty;
  assign rd_empty    = rd_en && empty;
  assign fill_nx     = fill_count + CNT_W'(wr_en) - CNT_W'(do_rd);

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (arm_ok) state_nx = S_CAPTURE;
      end
      S_CAPTURE: begin
        busy = 1'b1;
        if (stop || stop_pend) begin
          if (!vld_p0) state_nx = S_IDLE;
        end else if (ss_complete) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (stop)        state_nx = S_IDLE;
        else if (arm_ok) state_nx = S_CAPTURE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mode_q    <= 1'b0;
      len_q     <= '0;
      decim_q   <= '0;
      dec_cnt   <= '0;
      samp_cnt  <= '0;
      stop_pend <= 1'b0;
    end else begin
      state <= state_nx;
      if (state_nx != S_CAPTURE)        stop_pend <= 1'b0;
      else if (state == S_CAPTURE && stop) stop_pend <= 1'b1;
      if (arm_ok) begin
        mode_q   <= mode;
        len_q    <= capture_len;
        decim_q  <= decim;
        dec_cnt  <= '0;
        samp_cnt <= '0;
      end else begin
        if (live && sample_valid)
          dec_cnt <= (dec_cnt == decim_q) ? '0 : dec_cnt + 1'b1;
        if (last_word)
          samp_cnt <= samp_cnt + 1'b1;
      end
    end
  end

  // Stage p0: accepted sample held while its channels are emitted one per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      ch_p0  <= '0;
    end else if (accept) begin
      vld_p0 <= 1'b1;
      ch_p0  <= '0;
    end else if (last_word) begin
      vld_p0 <= 1'b0;
    end else if (vld_p0) begin
      ch_p0  <= ch_p0 + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept)      data_p0 <= sample_data;
    else if (vld_p0) data_p0 <= data_p0 >> PRECISION;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= pack_word(ch_p0, data_p0[PRECISION-1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_count <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      fill_count <= fill_nx;
      empty      <= (fill_nx == '0);
      full       <= (fill_nx == CNT_W'(DEPTH));
      rd_valid   <= rd_en;
      if (rd_en) rd_data <= empty ? 16'h0000 : mem[rd_ptr];
    end
  end

  // A flag event in the same cycle as clear_flags wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_sticky  <= 1'b0;
      underflow_sticky <= 1'b0;
      drop_count       <= '0;
    end else if (clear_flags) begin
      overflow_sticky  <= drop;
      underflow_sticky <= rd_empty;
      drop_count       <= drop ? 16'd1 : 16'd0;
    end else begin
      if (drop)     overflow_sticky  <= 1'b1;
      if (rd_empty) underflow_sticky <= 1'b1;
      if (drop)     drop_count       <= sat_inc(drop_count);
    end
  end

endmodule

// File: doc/adc_capture_buffer.md
Name: adc_capture_buffer

Overview:
- Single-clock, multi-channel ADC sample capture buffer with decimation, single-shot/continuous capture modes, channel tagging and sticky error flags.
- Packs each accepted multi-channel sample into tagged 16-bit words in an internal synchronous FIFO.
- Words are read out through a 1-cycle-latency read port that feeds the host pipe-out path.
- Sits between the ADC front-end capture register and the host-interface pipe endpoint.

Parameters:
- PRECISION, 10, ADC code width per channel (1..12).
- CHANNELS, 2, number of ADC channels per sample (1..16).
- DEPTH_LOG2, 10, FIFO depth = 2^DEPTH_LOG2 16-bit words.
- DECIM_WIDTH, 8, width of the decimation control.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sample_valid  in  1  one-cycle strobe: sample_data holds a new sample.
- sample_data  in  CHANNELS*PRECISION  channel k at bits [k*PRECISION +: PRECISION].
- arm  in  1  pulse: start capture.
- stop  in  1  pulse: abort capture, return to IDLE.
- mode  in  1  0 = continuous, 1 = single-shot; sampled on arm.
- capture_len  in  DEPTH_LOG2+1  single-shot sample count; sampled on arm.
- decim  in  DECIM_WIDTH  keep 1 of every decim+1 valid samples; sampled on arm.
- clear_flags  in  1  pulse: clear overflow_sticky, underflow_sticky and drop_count.
- rd_en  in  1  read request.
- rd_data  out  16  read word.
- rd_valid  out  1  rd_data valid (1 cycle after rd_en).
- fill_count  out  DEPTH_LOG2+1  words currently stored.
- empty  out  1  fill_count == 0.
- full  out  1  fill_count == 2^DEPTH_LOG2.
- busy  out  1  state is CAPTURE.
- done  out  1  single-shot complete.
- overflow_sticky  out  1  a sample was dropped.
- underflow_sticky  out  1  a read occurred while empty.
- drop_count  out  16  dropped samples, saturating.

Behaviour:
- Reset (rst_n low, async): state IDLE. All outputs 0 except empty = 1. FIFO pointers cleared, decimation and sample counters cleared. Reset mid-capture or mid-serialisation discards everything; no partial words survive.
- States: IDLE, CAPTURE, DONE.
  - IDLE --arm--> CAPTURE. This latches mode, capture_len and decim, clears the decimation counter, the sample counter and done.
  - CAPTURE --stop--> IDLE.
  - CAPTURE --(mode = 1 and sample counter == capture_len)--> DONE.
  - DONE --arm--> CAPTURE, with the same latching as from IDLE.
  - DONE --stop--> IDLE.
  - arm during CAPTURE is ignored. stop and arm in the same cycle: stop wins.
  - Single-shot with capture_len = 0 enters DONE on the cycle after arm, with no writes.
- done = 1 exactly while in DONE.
- Decimation:
  - Counts sample_valid strobes seen in CAPTURE.
  - The first valid after arm is a candidate; then every (decim+1)th valid is a candidate.
  - decim = 0 makes every valid a candidate.
- Acceptance: a candidate is accepted only if the serialiser is idle and free space >= CHANNELS.
  - Otherwise the whole sample is dropped: overflow_sticky = 1, drop_count += 1 (saturating at 0xFFFF).
  - Dropped samples do not advance the single-shot sample counter.
- Serialiser: an accepted sample is registered, then written as CHANNELS words on CHANNELS consecutive cycles starting the next cycle, channel 0 first.
  - Word format: [15:12] = channel index, [11:PRECISION] = 0, [PRECISION-1:0] = code.
  - The single-shot sample counter increments when the last word is written, so DONE is entered only after the final word.
  - stop during serialisation completes the in-flight sample's words, then IDLE. Channel alignment is always preserved.
- Read port:
  - rd_en with !empty pops one word; rd_data is registered and rd_valid = 1 on the next cycle.
  - rd_en with empty: next cycle rd_data = 0x0000, rd_valid = 1, underflow_sticky = 1. Pointers are unchanged.
  - rd_valid = 0 in any cycle following no rd_en; rd_data then holds its last value.
- Simultaneous write and read: both occur and fill_count is unchanged. A read while full frees space, and that space is visible to the acceptance check on the next cycle.
- fill_count, empty and full are registered and updated the same cycle as the pointers.
- Pointers wrap modulo 2^DEPTH_LOG2.
- clear_flags coincident with a new flag event: the flag stays set.

Test Plan:
- Reset, arm with mode = 1, capture_len = 3, decim = 0, CHANNELS = 2, then 3 valids spaced 4 cycles apart with ch0 = 0x155, ch1 = 0x2AA -> fill_count = 6, done = 1; reads return 0x0155, 0x12AA three times, each with rd_valid one cycle after rd_en.
- decim = 2, continuous, 9 valids with codes 0..8 on ch0 -> ch0 words 0, 3, 6 stored; stop -> IDLE, busy = 0.
- DEPTH_LOG2 = 2 (4 words), CHANNELS = 2, 3 samples, no reads -> 2 stored, overflow_sticky = 1, drop_count = 1, full = 1; clear_flags -> both flags 0.
- rd_en on empty FIFO -> rd_data = 0x0000, rd_valid = 1, underflow_sticky = 1, fill_count stays 0.
- Sustained rd_en during writes with fill_count = 3 -> fill_count stable on each simultaneous read+write cycle; word order preserved across pointer wrap.
- rst_n low mid-serialisation and mid-single-shot -> all outputs at reset values immediately (async); arm after release restarts cleanly with done = 0.
